// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode codes and
// oversampling constants common to the clock generator, receiver and
// transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Oversample ticks per bit and sample strobes per bit issued by the clkgen.
  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_SAMPLES    = 3;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   i_clk  - destination clock
//   i_rst  - asynchronous active-high reset, both flops load RST_VAL
//   i_d    - asynchronous input
//   o_q    - synchronized output
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive framer. Detects the start edge, asks the clock generator to
// realign its oversample count, majority-votes three sample strobes per bit,
// assembles data LSB first, checks optional parity and the stop bit, and
// offers each good word on a valid/ready interface.
// Ports:
//   i_clk, i_rst   - clock, asynchronous active-high reset
//   i_rx           - asynchronous serial line, idle high
//   i_rxpulse      - sample strobe from the clock generator
//   o_rxsync       - one-cycle realignment request to the clock generator
//   o_data/o_valid - received word and its valid flag
//   i_ready        - consumer accepts the word when o_valid & i_ready
//   o_frame_err    - one-cycle pulse, stop bit voted 0
//   o_parity_err   - one-cycle pulse, parity mismatch
//   o_overrun      - one-cycle pulse, good word dropped while o_valid held
//   o_busy         - receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_rxpulse,
  output logic                 o_rxsync,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_e          state, state_n;
  logic                 rx_s, rx_prev;
  logic [1:0]           samp_cnt, samp_cnt_n, vote_cnt, vote_cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic                 par_bit, par_bit_n;
  logic                 sync_n, valid_n, ferr_n, perr_n, ovr_n;
  logic                 fall, take, decide, bit_val, par_x, par_bad;
  logic [2:0]           votes;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  assign fall    = rx_prev & ~rx_s;
  // The strobe coinciding with o_rxsync belongs to the old count; drop it.
  assign take    = i_rxpulse & ~o_rxsync & (state != ST_IDLE);
  assign decide  = take & (samp_cnt == 2'(UART_SAMPLES - 1));
  assign votes   = {1'b0, vote_cnt} + {2'b00, rx_s};
  assign bit_val = (votes >= 3'd2);
  assign par_x   = (^shreg) ^ par_bit;

  always_comb begin
    par_bad = 1'b0;
    if (PARITY == PAR_ODD)       par_bad = ~par_x;
    else if (PARITY == PAR_EVEN) par_bad = par_x;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      rx_prev      <= 1'b1;
      samp_cnt     <= '0;
      vote_cnt     <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      o_rxsync     <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_n;
      rx_prev      <= rx_s;
      samp_cnt     <= samp_cnt_n;
      vote_cnt     <= vote_cnt_n;
      bit_idx      <= bit_idx_n;
      shreg        <= shreg_n;
      par_bit      <= par_bit_n;
      o_rxsync     <= sync_n;
      o_data       <= data_n;
      o_valid      <= valid_n;
      o_frame_err  <= ferr_n;
      o_parity_err <= perr_n;
      o_overrun    <= ovr_n;
      o_busy       <= (state_n != ST_IDLE);
    end
  end

  always_comb begin
    state_n    = state;
    samp_cnt_n = samp_cnt;
    vote_cnt_n = vote_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    data_n     = o_data;
    valid_n    = o_valid & ~i_ready;
    sync_n     = 1'b0;
    ferr_n     = 1'b0;
    perr_n     = 1'b0;
    ovr_n      = 1'b0;

    if (take) begin
      if (decide) begin
        samp_cnt_n = '0;
        vote_cnt_n = '0;
      end else begin
        samp_cnt_n = samp_cnt + 2'd1;
        vote_cnt_n = vote_cnt + {1'b0, rx_s};
      end
    end

    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_n    = ST_START;
          sync_n     = 1'b1;
          samp_cnt_n = '0;
          vote_cnt_n = '0;
        end
      end
      ST_START: begin
        if (decide) begin
          state_n   = bit_val ? ST_IDLE : ST_DATA;
          bit_idx_n = '0;
        end
      end
      ST_DATA: begin
        if (decide) begin
          shreg_n = {bit_val, shreg[DATA_BITS-1:1]};
          if (bit_idx == IDX_W'(DATA_BITS - 1))
            state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          else
            bit_idx_n = bit_idx + 1'b1;
        end
      end
      ST_PAR: begin
        if (decide) begin
          par_bit_n = bit_val;
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at the stop decision so a start edge half a bit early is caught.
        if (decide) begin
          state_n = ST_IDLE;
          ferr_n  = ~bit_val;
          perr_n  = par_bad;
          if (bit_val && !par_bad) begin
            // A word being accepted this cycle frees the slot: load wins.
            if (o_valid && !i_ready) begin
              ovr_n = 1'b1;
            end else begin
              data_n  = shreg;
              valid_n = 1'b1;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Four receivers (8N1, 8O1, 8E1, 5N1) each
// get their own serial line and a behavioural clock-generator model
// (4 clk per tick, 16 ticks per bit, strobes on ticks 5..7, restarted by
// o_rxsync). A frame-level reference model predicts accepted words and
// error/overrun/rxsync counts from the frame contents.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int NI     = 4;
  localparam int BITCLK = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] rx, rdy, pulse, sync, valid, ferr, perr, ovr, busy;
  logic [7:0]    dout [NI];

  int unsigned m_sync[NI], m_ferr[NI], m_perr[NI], m_ovr[NI], m_acc[NI];
  logic [7:0]  m_last[NI];
  int unsigned e_sync[NI], e_ferr[NI], e_perr[NI], e_ovr[NI], e_acc[NI];
  logic [7:0]  e_last[NI], e_held[NI];
  bit          e_hold[NI];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned DB = (g == 3) ? 5 : 8;
    localparam int unsigned PM = (g == 1) ? PAR_ODD : (g == 2) ? PAR_EVEN : PAR_NONE;
    logic [DB-1:0] d;
    logic [1:0]    div;
    logic [3:0]    os;

    uart_rx #(.DATA_BITS(DB), .PARITY(PM)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rx         (rx[g]),
      .i_rxpulse    (pulse[g]),
      .o_rxsync     (sync[g]),
      .o_data       (d),
      .o_valid      (valid[g]),
      .i_ready      (rdy[g]),
      .o_frame_err  (ferr[g]),
      .o_parity_err (perr[g]),
      .o_overrun    (ovr[g]),
      .o_busy       (busy[g])
    );
    assign dout[g] = 8'(d);

    always @(posedge clk or posedge rst) begin
      if (rst || sync[g]) begin
        div <= '0;
        os  <= '0;
      end else begin
        div <= div + 2'd1;
        if (div == 2'd3) os <= os + 4'd1;
      end
    end
    assign pulse[g] = (div == 2'd3) && (os >= 4'd5) && (os <= 4'd7);
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        if (sync[i]) m_sync[i]++;
        if (ferr[i]) m_ferr[i]++;
        if (perr[i]) m_perr[i]++;
        if (ovr[i])  m_ovr[i]++;
        if (valid[i] && rdy[i]) begin
          m_acc[i]++;
          m_last[i] = dout[i];
        end
      end
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned db_of(input int i);
    return (i == 3) ? 5 : 8;
  endfunction

  function automatic int unsigned pm_of(input int i);
    return (i == 1) ? PAR_ODD : (i == 2) ? PAR_EVEN : PAR_NONE;
  endfunction

  task automatic drive(input int i, input logic v, input int n);
    for (int c = 0; c < n; c++) begin
      rx[i] = v;
      @(posedge clk); #1;
    end
  endtask

  // Serial frame: start, data LSB first, optional parity, stop of stop_len clk.
  // corrupt flips one of the three sample points (early on even bits, late on odd).
  task automatic send_frame(input int i, input logic [7:0] d, input logic pb,
                            input logic stop, input int stop_len, input bit corrupt);
    logic fb [12];
    int   nb, len;
    logic v;
    nb = 0;
    fb[nb] = 1'b0; nb++;
    for (int k = 0; k < int'(db_of(i)); k++) begin
      fb[nb] = d[k]; nb++;
    end
    if (pm_of(i) != PAR_NONE) begin
      fb[nb] = pb; nb++;
    end
    fb[nb] = stop; nb++;
    for (int k = 0; k < nb; k++) begin
      len = (k == nb - 1) ? stop_len : BITCLK;
      for (int c = 0; c < len; c++) begin
        v = fb[k];
        if (corrupt && ((k % 2 == 0) ? (c >= 25 && c <= 27) : (c >= 33 && c <= 35)))
          v = ~v;
        rx[i] = v;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic model_frame(input int i, input logic [7:0] d, input logic pb, input logic stop);
    logic [7:0] w;
    logic       x;
    bit         pbad;
    w    = d & 8'((1 << db_of(i)) - 1);
    x    = (^w) ^ pb;
    pbad = (pm_of(i) == PAR_ODD) ? (x == 1'b0) : (pm_of(i) == PAR_EVEN) ? (x == 1'b1) : 1'b0;
    e_sync[i]++;
    if (!stop) e_ferr[i]++;
    if (pbad)  e_perr[i]++;
    if (stop && !pbad) begin
      if (e_hold[i]) e_ovr[i]++;
      else if (rdy[i]) begin
        e_acc[i]++;
        e_last[i] = w;
      end else begin
        e_hold[i] = 1'b1;
        e_held[i] = w;
      end
    end
  endtask

  task automatic frame(input int i, input logic [7:0] d, input logic pb, input logic stop);
    send_frame(i, d, pb, stop, BITCLK, 1'b0);
    model_frame(i, d, pb, stop);
    drive(i, 1'b1, 2 * BITCLK);
  endtask

  task automatic check_all(input int i, input string tag);
    @(negedge clk); #1;
    check({tag, ".rxsync"}, m_sync[i], e_sync[i]);
    check({tag, ".ferr"},   m_ferr[i], e_ferr[i]);
    check({tag, ".perr"},   m_perr[i], e_perr[i]);
    check({tag, ".ovr"},    m_ovr[i],  e_ovr[i]);
    check({tag, ".nacc"},   m_acc[i],  e_acc[i]);
    check({tag, ".data"},   m_last[i], e_last[i]);
  endtask

  initial begin
    logic [7:0] a, b;
    for (int i = 0; i < NI; i++) begin
      m_sync[i] = 0; m_ferr[i] = 0; m_perr[i] = 0; m_ovr[i] = 0; m_acc[i] = 0; m_last[i] = '0;
      e_sync[i] = 0; e_ferr[i] = 0; e_perr[i] = 0; e_ovr[i] = 0; e_acc[i] = 0; e_last[i] = '0;
      e_held[i] = '0; e_hold[i] = 1'b0;
    end
    rx  = '1;
    rdy = '1;

    repeat (3) @(negedge clk);
    check("reset.ctrl", {valid[0], ferr[0], perr[0], ovr[0], busy[0], sync[0]}, 0);
    check("reset.data", dout[0], 0);
    rst = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b1, 16);

    frame(0, 8'h55, 1'b0, 1'b1);
    check_all(0, "f55");

    // Start-bit glitch: low 16 clk then high.
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 4);
    check("glitch.busy_hi", busy[0], 1);
    drive(0, 1'b1, BITCLK - 20);
    check("glitch.busy_lo", busy[0], 0);
    e_sync[0]++;
    drive(0, 1'b1, BITCLK);
    check_all(0, "glitch");

    // 0xA3 with both parity values on the odd and even receivers.
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 2; i++) begin
        frame(i, 8'hA3, p[0], 1'b1);
        check_all(i, $sformatf("parA3.i%0d.p%0d", i, p));
      end
    end

    // Stop bit 0, then break for 10 bit times.
    send_frame(0, 8'h0F, 1'b0, 1'b0, BITCLK, 1'b0);
    model_frame(0, 8'h0F, 1'b0, 1'b0);
    drive(0, 1'b0, 10 * BITCLK);
    check("break.busy", busy[0], 0);
    drive(0, 1'b1, 2 * BITCLK);
    check_all(0, "break");

    // Consumer stalled: second word overruns.
    rdy[0] = 1'b0;
    frame(0, 8'h11, 1'b0, 1'b1);
    frame(0, 8'h22, 1'b0, 1'b1);
    @(negedge clk);
    check("hold.valid", valid[0], 1);
    check("hold.data", dout[0], 8'h11);
    @(posedge clk); #1;
    rdy[0] = 1'b1;
    @(negedge clk);
    check("accept.valid_same", valid[0], 1);
    @(negedge clk);
    check("accept.valid_next", valid[0], 0);
    e_hold[0] = 1'b0;
    e_acc[0]++;
    e_last[0] = e_held[0];
    check_all(0, "ovr");

    // Back-to-back frames, 9/16-bit stop, one minority sample corrupted per bit.
    a = 8'($urandom);
    b = 8'($urandom);
    send_frame(0, a, 1'b0, 1'b1, 36, 1'b1);
    model_frame(0, a, 1'b0, 1'b1);
    check("b2b.first", dout[0], a);
    send_frame(0, b, 1'b0, 1'b1, 36, 1'b1);
    model_frame(0, b, 1'b0, 1'b1);
    drive(0, 1'b1, 2 * BITCLK);
    check_all(0, "b2b");

    // Asynchronous reset in the middle of the data bits.
    drive(0, 1'b0, BITCLK);
    drive(0, 1'b1, BITCLK);
    drive(0, 1'b0, BITCLK);
    drive(0, 1'b1, BITCLK / 2);
    e_sync[0]++;
    check("midrst.busy_before", busy[0], 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst.ctrl", {valid[0], ferr[0], perr[0], ovr[0], busy[0], sync[0]}, 0);
    check("midrst.data", dout[0], 0);
    rx[0] = 1'b1;
    for (int i = 0; i < NI; i++) e_hold[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b1, BITCLK);
    frame(0, 8'hC3, 1'b0, 1'b1);
    check_all(0, "postrst");

    // Randomized frames on every receiver.
    for (int i = 0; i < NI; i++) begin
      for (int f = 0; f < 5; f++) begin
        a = 8'($urandom);
        frame(i, a, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
        check_all(i, $sformatf("rand.i%0d.f%0d", i, f));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
